switch_bounce_gen: RTL and testbench
====================================

SWITCH_BOUNCE_GEN -- requirements
Module: switch_bounce_gen

Interface
REQ-001 The block SHALL take parameter BOUNCES, default 3, meaning the number of extra away-and-back toggle pairs per transition (legal range 0..15).
REQ-002 The block SHALL take parameter GAP_BITS, default 3, meaning the width of the random gap field; each gap is 1..2^GAP_BITS cycles (legal range 1..8).
REQ-003 The block SHALL take parameter SETTLE_CYC, default 16, meaning the number of stable hold cycles after the last toggle (legal range 1..255).
REQ-004 The block SHALL take parameter SEED, default 16'hACE1, meaning the LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-005 The block SHALL take parameter RST_LVL, default 0, meaning the SW level at reset.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock, with all state on its rising edge.
REQ-007 The block SHALL have port AR_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port D, input, 1 bit: requested clean switch level.
REQ-009 The block SHALL have port SW, output, 1 bit: registered bouncy switch level presented to a debouncer.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while a bounce or settle sequence is in progress.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of a sequence.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, BOUNCE and SETTLE; internal register LVL holds the target level.
REQ-013 In IDLE, SW SHALL equal LVL, and D SHALL be sampled every cycle.
REQ-014 In IDLE, when D != LVL on a rising edge: LVL <= D, gap counter <= gap value G, toggle counter <= 2*BOUNCES+1, state <= BOUNCE, and BUSY <= 1.
REQ-015 In BOUNCE, the gap counter SHALL decrement each cycle; when it equals 1, SW SHALL invert, the toggle counter SHALL decrement, and the gap counter SHALL reload with a new G.
REQ-016 SW SHALL therefore first change G cycles after entering BOUNCE, toggle 2*BOUNCES+1 times in total, and end at LVL.
REQ-017 On the edge of the final toggle, the FSM SHALL enter SETTLE with the settle counter loaded to SETTLE_CYC.
REQ-018 In SETTLE, SW SHALL hold, and the counter SHALL decrement each cycle.
REQ-019 When the settle counter reaches 1, the FSM SHALL return to IDLE, drive DONE=1 for exactly that next cycle, and drive BUSY=0 in that same cycle.
REQ-020 D SHALL be ignored in BOUNCE and SETTLE.
REQ-021 A D value differing from LVL on the first IDLE cycle after DONE SHALL start a new sequence, so DONE and a new BUSY rise can be back to back.
REQ-022 The gap value SHALL be G = LFSR[GAP_BITS-1:0] + 1, with the counter sized GAP_BITS+1 bits; no modulo logic is permitted.
REQ-023 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting every cycle regardless of state, and SHALL never reach 0.
REQ-024 When BOUNCES=0, the sequence SHALL be one toggle after G cycles, then SETTLE.
REQ-025 SW, BUSY and DONE SHALL be driven directly from flops with no combinational path from D.

Reset
REQ-026 While AR_N=0, immediately and independent of CLK: SW=RST_LVL, LVL=RST_LVL, state=IDLE, BUSY=0, DONE=0, LFSR=SEED (or 16'hACE1 if SEED=0), and all counters=0.
REQ-027 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the sequence with no DONE pulse.
REQ-028 After reset release, the first rising edge SHALL evaluate D against RST_LVL per REQ-014.

Configuration
REQ-029 When macro SWITCH_BOUNCE_GEN_FIXED_GAP_EN is defined, G SHALL be the constant 2^GAP_BITS, the LFSR SHALL be omitted, and SEED SHALL be unused, giving deterministic timing.
REQ-030 When SWITCH_BOUNCE_GEN_FIXED_GAP_EN is undefined, G SHALL follow REQ-022 and REQ-023.

Verification
REQ-031 Fixed-gap test, with BOUNCES=3, GAP_BITS=2, SETTLE_CYC=8, RST_LVL=0: drive D 0->1 at cycle 0 -> BUSY=1 from cycle 1; SW toggles at cycles 5, 9, ..., 29 (7 toggles, final 1); DONE=1 at cycle 37; BUSY=0 at cycle 37.
REQ-032 D-ignore test: with the REQ-031 setup, pulse D back to 0 during cycles 10..12 -> sequence unchanged; D=1 at IDLE means no new sequence.
REQ-033 Reset-abort test: drive AR_N low at cycle 15 of the REQ-031 sequence -> SW=0, BUSY=0 asynchronously; no DONE pulse; after release with D=1, a full new sequence starts.
REQ-034 Random-gap test, with the macro undefined and SEED=16'h0001: run 50 transitions -> every gap is in 1..8 (GAP_BITS=3), every sequence has exactly 7 toggles, and SW final = D; the LFSR is never 0.
REQ-035 Edge-case test, with BOUNCES=0 and SETTLE_CYC=1: back-to-back D toggles -> one SW toggle per sequence, and DONE is followed immediately by BUSY=1 on the next cycle.

Source files
------------

// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen: turns clean level changes on D into a bouncy SW waveform with LFSR-timed gaps
// SWITCH_BOUNCE_GEN_FIXED_GAP_EN: drop the LFSR and use a constant 2^GAP_BITS gap
module switch_bounce_gen #(
  parameter int BOUNCES = 3,
  parameter int GAP_BITS = 3,
  parameter int SETTLE_CYC = 16,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic RST_LVL = 1'b0
) (
  input  logic CLK,
  input  logic AR_N,
  input  logic D,
  output logic SW,
  output logic BUSY,
  output logic DONE
);
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
  typedef logic [GAP_BITS:0] gap_t;
  localparam logic [4:0] TOG0 = 5'(2 * BOUNCES + 1);
  localparam logic [7:0] SET0 = 8'(SETTLE_CYC);
  state_t state, state_n;
  logic lvl, lvl_n, sw_n, busy_n, done_n;
  gap_t gap, gap_n, g;
  logic [4:0] tog, tog_n;
  logic [7:0] set_cnt, set_n;
`ifdef SWITCH_BOUNCE_GEN_FIXED_GAP_EN
  assign g = gap_t'(1) << GAP_BITS;
`else
  localparam logic [15:0] SEED_I = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  logic [15:0] lfsr;
  always_ff @(posedge CLK or negedge AR_N)
    if (!AR_N) lfsr <= SEED_I;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign g = gap_t'(lfsr[GAP_BITS-1:0]) + gap_t'(1);
`endif
  always_comb begin
    state_n = state;
    lvl_n = lvl;
    sw_n = SW;
    busy_n = BUSY;
    done_n = 1'b0;
    gap_n = gap;
    tog_n = tog;
    set_n = set_cnt;
    case (state)
      IDLE: begin
        sw_n = lvl;
        if (D != lvl) begin
          lvl_n = D;
          gap_n = g;
          tog_n = TOG0;
          state_n = BOUNCE;
          busy_n = 1'b1;
        end
      end
      BOUNCE:
        if (gap == gap_t'(1)) begin
          sw_n = ~SW;
          tog_n = tog - 5'd1;
          gap_n = g;
          if (tog == 5'd1) begin
            state_n = SETTLE;
            set_n = SET0;
          end
        end else gap_n = gap - gap_t'(1);
      SETTLE:
        if (set_cnt == 8'd1) begin
          state_n = IDLE;
          done_n = 1'b1;
          busy_n = 1'b0;
        end else set_n = set_cnt - 8'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge AR_N)
    if (!AR_N) begin
      state <= IDLE;
      lvl <= RST_LVL;
      SW <= RST_LVL;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      gap <= '0;
      tog <= '0;
      set_cnt <= '0;
    end else begin
      state <= state_n;
      lvl <= lvl_n;
      SW <= sw_n;
      BUSY <= busy_n;
      DONE <= done_n;
      gap <= gap_n;
      tog <= tog_n;
      set_cnt <= set_n;
    end
endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb_switch_bounce_gen: directed checks of bounce timing, D-ignore, reset abort, random gaps and back-to-back runs
module tb_switch_bounce_gen;
  logic clk, ar_n, d0, d1, d2;
  logic sw0, busy0, done0, sw1, busy1, done1, sw2, busy2, done2;
  logic [15:0] m0, m1, m2;
  int checks = 0;
  int errors = 0;

  switch_bounce_gen #(.BOUNCES(3), .GAP_BITS(2), .SETTLE_CYC(8), .SEED(16'h0001), .RST_LVL(1'b0)) u0 (
    .CLK(clk), .AR_N(ar_n), .D(d0), .SW(sw0), .BUSY(busy0), .DONE(done0));
  switch_bounce_gen #(.BOUNCES(0), .GAP_BITS(3), .SETTLE_CYC(1), .SEED(16'h0000), .RST_LVL(1'b1)) u1 (
    .CLK(clk), .AR_N(ar_n), .D(d1), .SW(sw1), .BUSY(busy1), .DONE(done1));
  switch_bounce_gen #(.BOUNCES(3), .GAP_BITS(3), .SETTLE_CYC(4), .SEED(16'h0001), .RST_LVL(1'b0)) u2 (
    .CLK(clk), .AR_N(ar_n), .D(d2), .SW(sw2), .BUSY(busy2), .DONE(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] m);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  endfunction

  // reference LFSRs, one per instance, stepping on the same edges as the DUTs
  always @(posedge clk or negedge ar_n)
    if (!ar_n) begin
      m0 <= 16'h0001;
      m1 <= 16'hACE1;
      m2 <= 16'h0001;
    end else begin
      m0 <= step(m0);
      m1 <= step(m1);
      m2 <= step(m2);
    end

  function automatic int gap_of(input logic [15:0] m, input int gb);
`ifdef SWITCH_BOUNCE_GEN_FIXED_GAP_EN
    return 1 << gb;
`else
    return (int'(m) & ((1 << gb) - 1)) + 1;
`endif
  endfunction

  function automatic logic sw_of(input int u);
    return (u == 0) ? sw0 : (u == 1) ? sw1 : sw2;
  endfunction
  function automatic logic busy_of(input int u);
    return (u == 0) ? busy0 : (u == 1) ? busy1 : busy2;
  endfunction
  function automatic logic done_of(input int u);
    return (u == 0) ? done0 : (u == 1) ? done1 : done2;
  endfunction
  function automatic logic [15:0] m_of(input int u);
    return (u == 0) ? m0 : (u == 1) ? m1 : m2;
  endfunction

  task automatic drive(input int u, input logic v);
    if (u == 0) d0 = v;
    else if (u == 1) d1 = v;
    else d2 = v;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle(input int u, input int n, input logic esw);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d idle%0d sw", u, i), sw_of(u), esw);
      chk($sformatf("u%0d idle%0d busy", u, i), busy_of(u), 1'b0);
      chk($sformatf("u%0d idle%0d done", u, i), done_of(u), 1'b0);
    end
  endtask

  // Drives D to v and follows the expected SW/BUSY/DONE timeline cycle by cycle.
  // Called at a negedge with the instance idle at level ~v.
  task automatic run(input int u, input logic v, input bit pulse, input int abort_at);
    int gb, ntog, nset, nxt, tog, dc, gnow;
    logic esw;
    gb = (u == 0) ? 2 : 3;
    ntog = (u == 1) ? 1 : 7;
    nset = (u == 0) ? 8 : (u == 1) ? 1 : 4;
    esw = ~v;
    nxt = 0;
    tog = 0;
    dc = 1000;
    for (int c = 1; c <= dc; c++) begin
      gnow = gap_of(m_of(u), gb);
      if (c == 1) nxt = 1 + gnow;
      else if (c == nxt) begin
        esw = ~esw;
        tog++;
        if (tog == ntog) dc = c + nset;
        else nxt = c + gnow;
      end
      drive(u, (pulse && c >= 10 && c <= 12) ? ~v : v);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("u%0d c%0d sw", u, c), sw_of(u), esw);
      chk($sformatf("u%0d c%0d busy", u, c), busy_of(u), c < dc);
      chk($sformatf("u%0d c%0d done", u, c), done_of(u), c == dc);
`ifndef SWITCH_BOUNCE_GEN_FIXED_GAP_EN
      if (u == 2) chk($sformatf("u2 c%0d lfsr nonzero", c), u2.lfsr != 16'h0000, 1'b1);
`endif
      if (c == abort_at) begin
        ar_n = 1'b0;
        #1;
        chk("abort sw", sw_of(u), 1'b0);
        chk("abort busy", busy_of(u), 1'b0);
        chk("abort done", done_of(u), 1'b0);
        return;
      end
    end
  endtask

  initial begin
    ar_n = 1'b0;
    d0 = 1'b0;
    d1 = 1'b1;
    d2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst u0 sw", sw0, 1'b0);
    chk("rst u0 busy", busy0, 1'b0);
    chk("rst u0 done", done0, 1'b0);
    chk("rst u1 sw", sw1, 1'b1);
    chk("rst u1 busy", busy1, 1'b0);
    chk("rst u2 sw", sw2, 1'b0);
    ar_n = 1'b1;
    idle(0, 3, 1'b0);
    idle(1, 1, 1'b1);
    // 0->1 with a D glitch back to 0 mid-bounce, then D held at the new level
    run(0, 1'b1, 1'b1, 0);
    idle(0, 5, 1'b1);
    run(0, 1'b0, 1'b0, 0);
    idle(0, 2, 1'b0);
    // reset lands mid-sequence; no DONE may follow, then a fresh sequence starts
    run(0, 1'b1, 1'b0, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in rst%0d done", i), done0, 1'b0);
      chk($sformatf("in rst%0d sw", i), sw0, 1'b0);
      chk($sformatf("in rst%0d busy", i), busy0, 1'b0);
    end
    ar_n = 1'b1;
    run(0, 1'b1, 1'b0, 0);
    idle(0, 3, 1'b1);
    // single-toggle, one-cycle-settle instance driven back to back
    idle(1, 1, 1'b1);
    run(1, 1'b0, 1'b0, 0);
    run(1, 1'b1, 1'b0, 0);
    run(1, 1'b0, 1'b0, 0);
    run(1, 1'b1, 1'b0, 0);
    idle(1, 2, 1'b1);
    for (int i = 0; i < 50; i++) run(2, (i % 2) == 0, 1'b0, 0);
    idle(2, 2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
